// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin synchronisation, deglitching, frame decoding
// and E0/F0 prefix folding into one strobed scancode per key event.

module ps2_line_filter #(
  parameter int LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  // cnt counts consecutive samples that disagree with the current level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       kbint,
  output logic       err
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic           fclk;
  logic           fdata;
  logic           fclk_q;
  logic           sample;
  logic [1:0]     state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par;
  logic           par_ok;
  logic [WDW-1:0] wd;
  logic           good;
  logic           bad;
  logic [7:0]     byte_q;
  logic           ext_pend;
  logic           rel_pend;

  ps2_line_filter #(.LEN(FILTER_LEN)) u_fclk (
    .clk  (clk),
    .rst  (rst),
    .raw  (clkps2),
    .filt (fclk)
  );

  ps2_line_filter #(.LEN(FILTER_LEN)) u_fdata (
    .clk  (clk),
    .rst  (rst),
    .raw  (dataps2),
    .filt (fdata)
  );

  always_ff @(posedge clk) begin
    if (rst) fclk_q <= 1'b1;
    else     fclk_q <= fclk;
  end

  assign sample = fclk_q & ~fclk;
  assign par_ok = ^{shreg, par};

  // Frame decoder; a sample event always beats a coincident timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      wd     <= '0;
      good   <= 1'b0;
      bad    <= 1'b0;
      byte_q <= '0;
    end else begin
      good <= 1'b0;
      bad  <= 1'b0;
      if (sample) begin
        wd <= '0;
        unique case (state)
          IDLE: begin
            if (!fdata) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {fdata, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= fdata;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (fdata && par_ok) begin
              good   <= 1'b1;
              byte_q <= shreg;
            end else begin
              bad <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (wd == WD_LAST) begin
          state <= IDLE;
          wd    <= '0;
          bad   <= 1'b1;
        end else begin
          wd <= wd + WD_ONE;
        end
      end else begin
        wd <= '0;
      end
    end
  end

  // Prefix folding and output update
  always_ff @(posedge clk) begin
    if (rst) begin
      scancode <= '0;
      extended <= 1'b0;
      released <= 1'b0;
      kbint    <= 1'b0;
      err      <= 1'b0;
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
    end else begin
      kbint <= 1'b0;
      err   <= 1'b0;
      if (bad) begin
        err      <= 1'b1;
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (good) begin
        if (byte_q == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          rel_pend <= 1'b1;
        end else begin
          scancode <= byte_q;
          extended <= ext_pend;
          released <= rel_pend;
          kbint    <= 1'b1;
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frame table plus timeout, glitch
// and mid-frame reset sequences.

module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 25000;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    int         half;
    int         glitch;
    int         exp_kb;
    int         exp_err;
    logic [7:0] exp_sc;
    bit         exp_ext;
    bit         exp_rel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkps2 = 1'b1;
  logic       dataps2 = 1'b1;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       kbint;
  logic       err;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int kb_cnt = 0;
  int err_cnt = 0;
  int kb_cyc = 0;
  int err_cyc = 0;
  int last_fall = 0;

  vec_t vecs[14];

  ps2_scancode_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clkps2   (clkps2),
    .dataps2  (dataps2),
    .scancode (scancode),
    .extended (extended),
    .released (released),
    .kbint    (kbint),
    .err      (err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kbint) begin
      kb_cnt++;
      kb_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (kbint && err) begin
      total++;
      bad++;
      $display("FAIL kbint_err_overlap: both high at cycle %0d, required never", cyc);
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] code, input bit bad_par,
                      input bit bad_stop, input int half,
                      input int glitch, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dataps2 = fr[i];
      if (i == glitch) begin
        ticks(20);
        clkps2 = 1'b0;
        ticks(3);
        clkps2 = 1'b1;
        ticks(half - 23);
      end else begin
        ticks(half);
      end
      clkps2 = 1'b0;
      last_fall = cyc;
      ticks(half);
      clkps2 = 1'b1;
    end
    dataps2 = 1'b1;
  endtask

  initial begin
    int k0;
    int e0;
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1000, -1, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 60, -1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 60, -1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{8'h75, 1'b0, 1'b0, 60, -1, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, 60, -1, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, 60, -1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[6]  = '{8'h1C, 1'b1, 1'b0, 60, -1, 0, 1, 8'h1C, 1'b0, 1'b0};
    vecs[7]  = '{8'h1C, 1'b0, 1'b0, 60, -1, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 60, -1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 60, -1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[10] = '{8'h5A, 1'b0, 1'b0, 60, -1, 1, 0, 8'h5A, 1'b1, 1'b1};
    vecs[11] = '{8'h66, 1'b0, 1'b1, 60, -1, 0, 1, 8'h5A, 1'b1, 1'b1};
    vecs[12] = '{8'hE1, 1'b0, 1'b0, 60, -1, 1, 0, 8'hE1, 1'b0, 1'b0};
    vecs[13] = '{8'h1C, 1'b0, 1'b0, 60, 4, 1, 0, 8'h1C, 1'b0, 1'b0};

    ticks(5);
    chk("rst_scancode", 32'(scancode), 32'h00);
    chk("rst_extended", 32'(extended), 32'h0);
    chk("rst_released", 32'(released), 32'h0);
    chk("rst_kbint", 32'(kbint), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    ticks(20);

    for (int i = 0; i < 14; i++) begin
      k0 = kb_cnt;
      e0 = err_cnt;
      send(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop,
           vecs[i].half, vecs[i].glitch, 11);
      ticks(40);
      chk($sformatf("v%0d_kbint_count", i), 32'(kb_cnt - k0),
          32'(vecs[i].exp_kb));
      chk($sformatf("v%0d_err_count", i), 32'(err_cnt - e0),
          32'(vecs[i].exp_err));
      chk($sformatf("v%0d_scancode", i), 32'(scancode),
          32'(vecs[i].exp_sc));
      chk($sformatf("v%0d_extended", i), 32'(extended),
          32'(vecs[i].exp_ext));
      chk($sformatf("v%0d_released", i), 32'(released),
          32'(vecs[i].exp_rel));
      if (vecs[i].exp_kb == 1)
        chk($sformatf("v%0d_kbint_latency", i), 32'(kb_cyc - last_fall),
            32'(FL + 4));
      if (vecs[i].exp_err == 1)
        chk($sformatf("v%0d_err_latency", i), 32'(err_cyc - last_fall),
            32'(FL + 4));
    end

    // E0 pending, then an abandoned frame that must time out
    send(8'hE0, 1'b0, 1'b0, 60, -1, 11);
    ticks(40);
    k0 = kb_cnt;
    e0 = err_cnt;
    send(8'h29, 1'b0, 1'b0, 60, -1, 5);
    ticks(30000);
    chk("to_err_count", 32'(err_cnt - e0), 32'd1);
    chk("to_kbint_count", 32'(kb_cnt - k0), 32'd0);
    chk("to_err_latency", 32'(err_cyc - last_fall), 32'(TO + FL + 4));
    chk("to_scancode_held", 32'(scancode), 32'h1C);
    k0 = kb_cnt;
    send(8'h29, 1'b0, 1'b0, 60, -1, 11);
    ticks(40);
    chk("after_to_kbint", 32'(kb_cnt - k0), 32'd1);
    chk("after_to_scancode", 32'(scancode), 32'h29);
    chk("after_to_extended", 32'(extended), 32'h0);

    // F0 pending, partial frame, then reset mid-frame
    send(8'hF0, 1'b0, 1'b0, 60, -1, 11);
    ticks(40);
    send(8'h5A, 1'b0, 1'b0, 60, -1, 6);
    ticks(10);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(1);
    chk("mid_rst_scancode", 32'(scancode), 32'h00);
    chk("mid_rst_extended", 32'(extended), 32'h0);
    chk("mid_rst_released", 32'(released), 32'h0);
    ticks(20);
    k0 = kb_cnt;
    e0 = err_cnt;
    send(8'h5A, 1'b0, 1'b0, 60, -1, 11);
    ticks(40);
    chk("post_rst_kbint", 32'(kb_cnt - k0), 32'd1);
    chk("post_rst_err", 32'(err_cnt - e0), 32'd0);
    chk("post_rst_scancode", 32'(scancode), 32'h5A);
    chk("post_rst_released", 32'(released), 32'h0);
    chk("post_rst_latency", 32'(kb_cyc - last_fall), 32'(FL + 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
